// File: rtl/mips_boot_pkg.sv
// Shared types for the MIPS boot/run controller: load targets, controller states and header decode.
package mips_boot_pkg;

    typedef enum logic [1:0] {
        TGT_IMEM  = 2'b00,
        TGT_DMEM  = 2'b01,
        TGT_REG   = 2'b10,
        TGT_START = 2'b11
    } tgt_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DONE,
        ERR
    } state_e;

    localparam int TGT_MSB    = 31;
    localparam int TGT_LSB    = 30;
    localparam int CNT_MSB    = 29;
    localparam int CNT_LSB    = 16;
    localparam int BASE_MSB   = 15;
    localparam int BASE_LSB   = 0;
    localparam int HDR_CNT_W  = CNT_MSB - CNT_LSB + 1;
    localparam int HDR_BASE_W = BASE_MSB - BASE_LSB + 1;

    typedef struct packed {
        tgt_e                  tgt;
        logic [HDR_CNT_W-1:0]  count;
        logic [HDR_BASE_W-1:0] base;
    } hdr_t;

    function automatic hdr_t hdr_decode(input logic [31:0] word);
        hdr_t h;
        h.tgt   = tgt_e'(word[TGT_MSB:TGT_LSB]);
        h.count = word[CNT_MSB:CNT_LSB];
        h.base  = word[BASE_MSB:BASE_LSB];
        return h;
    endfunction

endpackage

// File: rtl/mips_boot_loader.sv
// Boot/run controller: streams headers+payload into imem/dmem/regfile, then runs the core against a cycle budget.
// Optional PC self-loop halt detection is enabled by defining MIPS_BOOT_PC_HALT_EN.
module mips_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 8,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 32
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                LdValid,
    output logic                LdReady,
    input  logic [DATA_W-1:0]   LdData,
    input  logic                Abort,
    input  logic [DATA_W-1:0]   PcIn,
    output logic                CpuRst,
    output logic                ImemWe,
    output logic [IMEM_AW-1:0]  ImemAddr,
    output logic                DmemWe,
    output logic [DMEM_AW-1:0]  DmemAddr,
    output logic                RegWe,
    output logic [REG_AW-1:0]   RegAddr,
    output logic [DATA_W-1:0]   WrData,
    output logic                Busy,
    output logic                Done,
    output logic                Err,
    output logic                Halted,
    output logic [CNT_W-1:0]    CycleCount
);

    localparam logic [HDR_BASE_W-1:0] IMEM_MASK = HDR_BASE_W'((32'd1 << IMEM_AW) - 32'd1);
    localparam logic [HDR_BASE_W-1:0] DMEM_MASK = HDR_BASE_W'((32'd1 << DMEM_AW) - 32'd1);
    localparam logic [HDR_BASE_W-1:0] REG_MASK  = HDR_BASE_W'((32'd1 << REG_AW) - 32'd1);
    localparam logic [HDR_BASE_W-1:0] ADDR_ONE  = HDR_BASE_W'(1);
    localparam logic [HDR_CNT_W-1:0]  CNT_ONE   = HDR_CNT_W'(1);
    localparam logic [CNT_W-1:0]      CYC_ONE   = CNT_W'(1);

    function automatic logic [HDR_BASE_W-1:0] tgt_mask(input tgt_e t);
        case (t)
            TGT_IMEM: return IMEM_MASK;
            TGT_DMEM: return DMEM_MASK;
            default:  return REG_MASK;
        endcase
    endfunction

    state_e                 state_q, state_d;
    tgt_e                   tgt_q, tgt_d;
    logic [HDR_BASE_W-1:0]  addr_q, addr_d;
    logic [HDR_CNT_W-1:0]   remaining_q, remaining_d;
    logic [HDR_BASE_W-1:0]  budget_q, budget_d;
    logic [CNT_W-1:0]       cycle_q, cycle_d;
    logic                   ld_ready_q, ld_ready_d;
    logic                   cpu_rst_q, cpu_rst_d;
    logic                   imem_we_q, imem_we_d;
    logic                   dmem_we_q, dmem_we_d;
    logic                   reg_we_q, reg_we_d;
    logic [IMEM_AW-1:0]     imem_addr_q, imem_addr_d;
    logic [DMEM_AW-1:0]     dmem_addr_q, dmem_addr_d;
    logic [REG_AW-1:0]      reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]      wr_data_q, wr_data_d;

    hdr_t                   hdr;
    logic                   hs;
    logic [CNT_W-1:0]       cycle_inc;
    logic                   budget_hit;

`ifdef MIPS_BOOT_PC_HALT_EN
    logic [DATA_W-1:0]      pc_prev_q, pc_prev_d;
    logic                   pc_valid_q, pc_valid_d;
    logic                   pc_same_q, pc_same_d;
    logic                   halted_q, halted_d;
    logic                   pc_same;
    logic                   pc_halt;

    // A PC is only comparable once its predecessor was also sampled in RUN.
    assign pc_same = (state_q == RUN) && pc_valid_q && (PcIn == pc_prev_q);
    assign pc_halt = pc_same && pc_same_q;
    assign Halted  = halted_q;
`else
    logic unused_pc;
    assign unused_pc = ^PcIn;
    assign Halted    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        budget_d    = budget_q;
        cycle_d     = cycle_q;
        imem_we_d   = 1'b0;
        dmem_we_d   = 1'b0;
        reg_we_d    = 1'b0;
        imem_addr_d = imem_addr_q;
        dmem_addr_d = dmem_addr_q;
        reg_addr_d  = reg_addr_q;
        wr_data_d   = wr_data_q;
        hdr         = hdr_decode(LdData[31:0]);
        hs          = LdValid & ld_ready_q;
        cycle_inc   = (&cycle_q) ? cycle_q : cycle_q + CYC_ONE;
        budget_hit  = (budget_q != '0) && (cycle_inc == CNT_W'(budget_q));
`ifdef MIPS_BOOT_PC_HALT_EN
        pc_prev_d   = PcIn;
        pc_valid_d  = (state_q == RUN);
        pc_same_d   = pc_same;
        halted_d    = halted_q;
`endif

        case (state_q)
            IDLE: begin
                if (hs) begin
                    if (hdr.tgt == TGT_START) begin
                        state_d  = RUN;
                        budget_d = hdr.base;
                        cycle_d  = '0;
                    end else if ((hdr.base & ~tgt_mask(hdr.tgt)) != '0) begin
                        state_d = ERR;
                    end else if (hdr.count != '0) begin
                        state_d     = LOAD;
                        tgt_d       = hdr.tgt;
                        addr_d      = hdr.base;
                        remaining_d = hdr.count;
                    end
                end
            end
            LOAD: begin
                if (hs) begin
                    wr_data_d = LdData;
                    case (tgt_q)
                        TGT_IMEM: begin
                            imem_we_d   = 1'b1;
                            imem_addr_d = addr_q[IMEM_AW-1:0];
                        end
                        TGT_DMEM: begin
                            dmem_we_d   = 1'b1;
                            dmem_addr_d = addr_q[DMEM_AW-1:0];
                        end
                        TGT_REG: begin
                            // $zero is hardwired in the core: consume the word but never write it.
                            reg_we_d   = (addr_q[REG_AW-1:0] != '0);
                            reg_addr_d = addr_q[REG_AW-1:0];
                        end
                        default: ;
                    endcase
                    addr_d      = (addr_q + ADDR_ONE) & tgt_mask(tgt_q);
                    remaining_d = remaining_q - CNT_ONE;
                    if (remaining_q == CNT_ONE) begin
                        state_d = IDLE;
                    end
                end
            end
            RUN: begin
                cycle_d = cycle_inc;
                if (Abort || budget_hit) begin
                    state_d = DONE;
                end
`ifdef MIPS_BOOT_PC_HALT_EN
                else if (pc_halt) begin
                    state_d  = DONE;
                    halted_d = 1'b1;
                end
`endif
            end
            default: ;
        endcase

        ld_ready_d = (state_d == IDLE) || (state_d == LOAD);
        cpu_rst_d  = (state_d != RUN);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            tgt_q       <= TGT_IMEM;
            addr_q      <= '0;
            remaining_q <= '0;
            budget_q    <= '0;
            cycle_q     <= '0;
            ld_ready_q  <= 1'b0;
            cpu_rst_q   <= 1'b1;
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            imem_addr_q <= '0;
            dmem_addr_q <= '0;
            reg_addr_q  <= '0;
            wr_data_q   <= '0;
`ifdef MIPS_BOOT_PC_HALT_EN
            pc_prev_q   <= '0;
            pc_valid_q  <= 1'b0;
            pc_same_q   <= 1'b0;
            halted_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            budget_q    <= budget_d;
            cycle_q     <= cycle_d;
            ld_ready_q  <= ld_ready_d;
            cpu_rst_q   <= cpu_rst_d;
            imem_we_q   <= imem_we_d;
            dmem_we_q   <= dmem_we_d;
            reg_we_q    <= reg_we_d;
            imem_addr_q <= imem_addr_d;
            dmem_addr_q <= dmem_addr_d;
            reg_addr_q  <= reg_addr_d;
            wr_data_q   <= wr_data_d;
`ifdef MIPS_BOOT_PC_HALT_EN
            pc_prev_q   <= pc_prev_d;
            pc_valid_q  <= pc_valid_d;
            pc_same_q   <= pc_same_d;
            halted_q    <= halted_d;
`endif
        end
    end

    assign LdReady    = ld_ready_q;
    assign CpuRst     = cpu_rst_q;
    assign ImemWe     = imem_we_q;
    assign ImemAddr   = imem_addr_q;
    assign DmemWe     = dmem_we_q;
    assign DmemAddr   = dmem_addr_q;
    assign RegWe      = reg_we_q;
    assign RegAddr    = reg_addr_q;
    assign WrData     = wr_data_q;
    assign Busy       = (state_q == LOAD) || (state_q == RUN);
    assign Done       = (state_q == DONE);
    assign Err        = (state_q == ERR);
    assign CycleCount = cycle_q;

endmodule
